sockit_spi_rpk: RTL and testbench

Output repackager between the clock-domain-crossing stage and the serializer, clocked in the SPI domain. It consumes 32-bit command words and 32-bit write-data words, and emits one 8-bit queue packet per SPI byte slot, with per-byte control bits for the serializer. Commands without output data produce filler bytes and do not touch the data stream.

---
 rtl/sockit_spi_pkg.sv | 38 +++
 rtl/sockit_spi_rpk.sv | 164 ++++++++++++++++
 tb/tb_sockit_spi_rpk.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sockit_spi_pkg.sv
// Shared types for the SoCkit SPI output path: command and queue packet
// layouts, IO mode codes and the repackager FSM state encoding.
package sockit_spi_pkg;

   localparam int CNW_DEF = 16;
   localparam int QUE_W   = 14;

   localparam logic [1:0] IOM_3WR = 2'd0;
   localparam logic [1:0] IOM_SGL = 2'd1;
   localparam logic [1:0] IOM_DUA = 2'd2;
   localparam logic [1:0] IOM_QUA = 2'd3;

   // command word: byte count minus one in the low bits, control flags above
   typedef struct packed {
      logic               lst;
      logic               sso;
      logic               die;
      logic               doe;
      logic [1:0]         iom;
      logic [CNW_DEF-1:0] cnt;
   } cmd_t;

   // one serializer byte slot with its per-byte control bits
   typedef struct packed {
      logic [7:0] dat;
      logic [1:0] iom;
      logic       doe;
      logic       die;
      logic       sso;
      logic       lst;
   } que_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BYTE = 1'b1
   } rpk_state_t;

endpackage

// File: rtl/sockit_spi_rpk.sv
// Output repackager: splits 32-bit write-data words into per-byte queue
// packets carrying the command's control bits. Filler bytes (00) are made
// when the command has no output data. Byte order inside a word is MSB first;
// define SOCKIT_SPI_RPK_LSB_EN to send the LSB byte first instead.
module sockit_spi_rpk
   import sockit_spi_pkg::*;
#(
   parameter int CNW = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             scw_vld,
   output logic             scw_rdy,
   input  logic [CNW+5:0]   scw_dat,
   input  logic             sdw_vld,
   output logic             sdw_rdy,
   input  logic [31:0]      sdw_dat,
   output logic             quo_vld,
   input  logic             quo_rdy,
   output logic [QUE_W-1:0] quo_dat
);

   rpk_state_t     state_q, state_d;
   logic [1:0]     iom_q, iom_d;
   logic           doe_q, doe_d;
   logic           die_q, die_d;
   logic           sso_q, sso_d;
   logic           lst_q, lst_d;
   logic [CNW-1:0] bc_q, bc_d;
   logic [1:0]     bi_q, bi_d;
   logic [31:0]    wrd_q, wrd_d;
   logic           wvl_q, wvl_d;

   logic           last_s;
   logic           quo_xfer_s;
   logic           reload_s;
   logic           sdw_xfer_s;
   logic [7:0]     byte_s;
   que_t           que_s;

   // handshake decode; a word boundary inside a command reloads in the same cycle
   always_comb begin
      last_s     = (bc_q == {CNW{1'b0}});
      scw_rdy    = (state_q == ST_IDLE);
      quo_vld    = (state_q == ST_BYTE) && (!doe_q || wvl_q);
      quo_xfer_s = quo_vld && quo_rdy;
      reload_s   = quo_xfer_s && (bi_q == 2'd3) && !last_s;
      sdw_rdy    = (state_q == ST_BYTE) && doe_q && (!wvl_q || reload_s);
      sdw_xfer_s = sdw_vld && sdw_rdy;
   end

   // pick the current byte lane out of the held word
   always_comb begin
      case (bi_q)
`ifdef SOCKIT_SPI_RPK_LSB_EN
         2'd0:    byte_s = wrd_q[7:0];
         2'd1:    byte_s = wrd_q[15:8];
         2'd2:    byte_s = wrd_q[23:16];
         2'd3:    byte_s = wrd_q[31:24];
`else
         2'd0:    byte_s = wrd_q[31:24];
         2'd1:    byte_s = wrd_q[23:16];
         2'd2:    byte_s = wrd_q[15:8];
         2'd3:    byte_s = wrd_q[7:0];
`endif
         default: byte_s = 8'h00;
      endcase
   end

   // assemble the queue packet; lst only marks the final byte of the command
   always_comb begin
      que_s.dat = doe_q ? byte_s : 8'h00;
      que_s.iom = iom_q;
      que_s.doe = doe_q;
      que_s.die = die_q;
      que_s.sso = sso_q;
      que_s.lst = lst_q && last_s;
      quo_dat   = que_s;
   end

   // next-state: command latch, byte counters and word register
   always_comb begin
      state_d = state_q;
      iom_d   = iom_q;
      doe_d   = doe_q;
      die_d   = die_q;
      sso_d   = sso_q;
      lst_d   = lst_q;
      bc_d    = bc_q;
      bi_d    = bi_q;
      wrd_d   = wrd_q;
      wvl_d   = wvl_q;
      case (state_q)
         ST_IDLE: begin
            if (scw_vld) begin
               bc_d    = scw_dat[CNW-1:0];
               iom_d   = scw_dat[CNW+1:CNW];
               doe_d   = scw_dat[CNW+2];
               die_d   = scw_dat[CNW+3];
               sso_d   = scw_dat[CNW+4];
               lst_d   = scw_dat[CNW+5];
               bi_d    = 2'd0;
               wvl_d   = 1'b0;
               state_d = ST_BYTE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BYTE: begin
            if (quo_xfer_s) begin
               bi_d = bi_q + 2'd1;
               if (last_s) begin
                  // trailing bytes of the final word are discarded here
                  bc_d    = {CNW{1'b0}};
                  wvl_d   = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  bc_d  = bc_q - {{(CNW-1){1'b0}}, 1'b1};
                  wvl_d = (bi_q == 2'd3) ? 1'b0 : wvl_q;
               end
            end else begin
               bc_d = bc_q;
            end
            if (sdw_xfer_s) begin
               wrd_d = sdw_dat;
               wvl_d = 1'b1;
            end else begin
               wrd_d = wrd_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         iom_q   <= 2'd0;
         doe_q   <= 1'b0;
         die_q   <= 1'b0;
         sso_q   <= 1'b0;
         lst_q   <= 1'b0;
         bc_q    <= {CNW{1'b0}};
         bi_q    <= 2'd0;
         wrd_q   <= 32'h0000_0000;
         wvl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         iom_q   <= iom_d;
         doe_q   <= doe_d;
         die_q   <= die_d;
         sso_q   <= sso_d;
         lst_q   <= lst_d;
         bc_q    <= bc_d;
         bi_q    <= bi_d;
         wrd_q   <= wrd_d;
         wvl_q   <= wvl_d;
      end
   end

endmodule

// File: tb/tb_sockit_spi_rpk.sv
// Directed bench for sockit_spi_rpk; honours SOCKIT_SPI_RPK_LSB_EN for byte order.
module tb_sockit_spi_rpk;
   import sockit_spi_pkg::*;

   localparam int CNW = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             scw_vld, scw_rdy;
   logic [CNW+5:0]   scw_dat;
   logic             sdw_vld, sdw_rdy;
   logic [31:0]      sdw_dat;
   logic             quo_vld, quo_rdy;
   que_t             quo_dat;

   always #5 clk = ~clk;

   sockit_spi_rpk #(.CNW(CNW)) dut (
      .clk     (clk),
      .rst     (rst),
      .scw_vld (scw_vld),
      .scw_rdy (scw_rdy),
      .scw_dat (scw_dat),
      .sdw_vld (sdw_vld),
      .sdw_rdy (sdw_rdy),
      .sdw_dat (sdw_dat),
      .quo_vld (quo_vld),
      .quo_rdy (quo_rdy),
      .quo_dat (quo_dat)
   );

   int          n_chk = 0;
   int          n_err = 0;
   string       tname = "init";
   int          cyc = 0;
   int          sdw_cnt = 0;
   bit          stall_q = 1'b0;
   bit          stall_s = 1'b0;
   bit          prev_hold = 1'b0;
   que_t        prev_dat;
   cmd_t        cq[$];
   logic [31:0] wq[$];
   que_t        eq[$];
   int          byte_cyc[$];
   int          acc_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s.%s got=%h exp=%h", tname, tag, got, exp);
      end
   endtask

   function automatic cmd_t mk_cmd(input int cnt, input logic [1:0] iom, input logic doe,
                                   input logic die, input logic sso, input logic lst);
      cmd_t c;
      c.cnt = cnt[CNW-1:0];
      c.iom = iom;
      c.doe = doe;
      c.die = die;
      c.sso = sso;
      c.lst = lst;
      return c;
   endfunction

   function automatic que_t mk_que(input logic [7:0] dat, input logic [1:0] iom, input logic doe,
                                   input logic die, input logic sso, input logic lst);
      que_t q;
      q.dat = dat;
      q.iom = iom;
      q.doe = doe;
      q.die = die;
      q.sso = sso;
      q.lst = lst;
      return q;
   endfunction

   // reference byte order for the long stalled command
   function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
`ifdef SOCKIT_SPI_RPK_LSB_EN
      return w[8*i +: 8];
`else
      return w[31-8*i -: 8];
`endif
   endfunction

   task automatic drive();
      scw_vld = (cq.size() > 0);
      scw_dat = (cq.size() > 0) ? cq[0] : '0;
      sdw_vld = (wq.size() > 0) && (!stall_s || ($urandom_range(0, 1) != 0));
      sdw_dat = (wq.size() > 0) ? wq[0] : 32'h0;
      quo_rdy = !stall_q || ($urandom_range(0, 2) != 0);
   endtask

   // sample just before the rising edge, then re-drive after the falling edge
   task automatic tick();
      #3;
      if (prev_hold) begin
         check("hold_vld", quo_vld, 1'b1);
         check("hold_dat", quo_dat, prev_dat);
      end
      prev_hold = quo_vld && !quo_rdy;
      prev_dat  = quo_dat;
      if (quo_vld && quo_rdy) begin
         if (eq.size() == 0) check("extra_byte", quo_vld, 1'b0);
         else begin
            check("byte", quo_dat, eq.pop_front());
            byte_cyc.push_back(cyc);
         end
      end
      if (sdw_vld && sdw_rdy) begin
         void'(wq.pop_front());
         sdw_cnt++;
      end
      if (scw_vld && scw_rdy) begin
         void'(cq.pop_front());
         acc_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
      drive();
   endtask

   task automatic run(input int bound);
      int n = 0;
      while ((eq.size() > 0 || cq.size() > 0) && n < bound) begin
         tick();
         n++;
      end
      check("timeout", eq.size() + cq.size(), 0);
   endtask

   initial begin
      int sdw0;
      int n;
      rst = 1'b1;
      drive();
      @(negedge clk);
      #1;
      tname = "reset";
      check("scw_rdy", scw_rdy, 1'b1);
      check("sdw_rdy", sdw_rdy, 1'b0);
      check("quo_vld", quo_vld, 1'b0);
      check("quo_dat", quo_dat, 14'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("scw_rdy_rel", scw_rdy, 1'b1);
      check("quo_vld_rel", quo_vld, 1'b0);

      // 1: eight bytes over a word boundary, then a filler command
      tname = "t1";
      byte_cyc.delete(); acc_cyc.delete();
      cq.push_back(mk_cmd(7, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
      cq.push_back(mk_cmd(0, IOM_SGL, 1'b0, 1'b0, 1'b1, 1'b1));
      wq.push_back(32'h11223344); wq.push_back(32'h55667788);
`ifdef SOCKIT_SPI_RPK_LSB_EN
      foreach (eq[i]) ;
      eq.push_back(mk_que(8'h44, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h33, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h22, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h11, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h88, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h77, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h66, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h55, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
`else
      eq.push_back(mk_que(8'h11, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h22, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h33, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h44, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h55, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h66, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h77, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h88, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
`endif
      eq.push_back(mk_que(8'h00, IOM_SGL, 1'b0, 1'b0, 1'b1, 1'b1));
      drive();
      run(200);
      check("n_bytes", byte_cyc.size(), 9);
      check("n_acc", acc_cyc.size(), 2);
      if (byte_cyc.size() == 9 && acc_cyc.size() == 2) begin
         check("lat_doe1", byte_cyc[0] - acc_cyc[0], 2);
         for (int k = 1; k < 8; k++) check("consec", byte_cyc[k] - byte_cyc[0], k);
         check("next_acc", acc_cyc[1] - byte_cyc[7], 1);
         check("lat_doe0", byte_cyc[8] - acc_cyc[1], 1);
      end

      // 2: partial final word is dropped, next command starts on a fresh word
      tname = "t2";
      sdw0 = sdw_cnt;
      cq.push_back(mk_cmd(5, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      cq.push_back(mk_cmd(0, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
      wq.push_back(32'hAABBCCDD); wq.push_back(32'h01020304); wq.push_back(32'h0000EE00);
`ifdef SOCKIT_SPI_RPK_LSB_EN
      eq.push_back(mk_que(8'hDD, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hCC, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hBB, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hAA, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h04, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h03, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
`else
      eq.push_back(mk_que(8'hAA, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hBB, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hCC, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hDD, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h01, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h02, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
`endif
      eq.push_back(mk_que(8'h00, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
      drive();
      run(200);
      check("words_used", sdw_cnt - sdw0, 3);
      check("wq_empty", wq.size(), 0);

      // 3: filler-only command never reads the data stream
      tname = "t3";
      byte_cyc.delete(); acc_cyc.delete();
      sdw0 = sdw_cnt;
      cq.push_back(mk_cmd(3, IOM_DUA, 1'b0, 1'b1, 1'b1, 1'b0));
      wq.push_back(32'hDEADBEEF);
      for (int k = 0; k < 4; k++) eq.push_back(mk_que(8'h00, IOM_DUA, 1'b0, 1'b1, 1'b1, 1'b0));
      drive();
      run(100);
      check("sdw_reads", sdw_cnt - sdw0, 0);
      check("wq_left", wq.size(), 1);
      check("n_bytes", byte_cyc.size(), 4);
      if (byte_cyc.size() == 4 && acc_cyc.size() == 1) begin
         check("lat", byte_cyc[0] - acc_cyc[0], 1);
         check("consec", byte_cyc[3] - byte_cyc[0], 3);
      end
      wq.delete();
      drive();

      // 4: 64-byte command with random stalls on both sides
      tname = "t4";
      stall_q = 1'b1;
      stall_s = 1'b1;
      cq.push_back(mk_cmd(63, IOM_QUA, 1'b1, 1'b0, 1'b1, 1'b1));
      for (int k = 0; k < 16; k++) begin
         logic [31:0] w;
         w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
         wq.push_back(w);
         for (int b = 0; b < 4; b++)
            eq.push_back(mk_que(byte_of(w, b), IOM_QUA, 1'b1, 1'b0, 1'b1, (k == 15 && b == 3)));
      end
      drive();
      run(3000);
      stall_q = 1'b0;
      stall_s = 1'b0;
      prev_hold = 1'b0;
      drive();

      // 5: reset mid-command drops the partial word
      tname = "t5";
      cq.push_back(mk_cmd(7, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
      wq.push_back(32'hA1A2A3A4); wq.push_back(32'hB1B2B3B4);
      for (int k = 0; k < 8; k++) eq.push_back(mk_que(8'h00, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
`ifdef SOCKIT_SPI_RPK_LSB_EN
      eq[0].dat = 8'hA4; eq[1].dat = 8'hA3; eq[2].dat = 8'hA2;
`else
      eq[0].dat = 8'hA1; eq[1].dat = 8'hA2; eq[2].dat = 8'hA3;
`endif
      drive();
      n = 0;
      while (eq.size() > 5 && n < 100) begin
         tick();
         n++;
      end
      check("three_bytes", eq.size(), 5);
      rst = 1'b1;
      #1;
      check("rst_quo_vld", quo_vld, 1'b0);
      check("rst_scw_rdy", scw_rdy, 1'b1);
      check("rst_sdw_rdy", sdw_rdy, 1'b0);
      check("rst_quo_dat", quo_dat, 14'h0);
      @(negedge clk);
      check("rst_hold_vld", quo_vld, 1'b0);
      rst = 1'b0;
      eq.delete(); wq.delete(); cq.delete();
      prev_hold = 1'b0;
      cq.push_back(mk_cmd(1, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
      wq.push_back(32'hC0DEBEEF);
`ifdef SOCKIT_SPI_RPK_LSB_EN
      eq.push_back(mk_que(8'hEF, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hBE, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
`else
      eq.push_back(mk_que(8'hC0, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'hDE, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
`endif
      drive();
      run(100);

      // 6: byte order of a single word
      tname = "t6";
      cq.push_back(mk_cmd(3, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
      wq.push_back(32'h11223344);
`ifdef SOCKIT_SPI_RPK_LSB_EN
      eq.push_back(mk_que(8'h44, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h33, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h22, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h11, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
`else
      eq.push_back(mk_que(8'h11, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h22, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h33, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b0));
      eq.push_back(mk_que(8'h44, IOM_SGL, 1'b1, 1'b0, 1'b1, 1'b1));
`endif
      drive();
      run(100);
      tick();
      tick();
      check("idle_end", scw_rdy, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
